// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer for breaking a ready/valid pipeline.
// It also keeps a saturating count of the cycles where downstream back-pressure stalls a live entry.
module pipe_skid_stage #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned STALL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         occupancy,
  output logic [STALL_W-1:0] stall_cnt
);

  // The state encoding equals the number of live entries.
  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StOne   = 2'd1;
  localparam logic [1:0] StFull  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   main_q, main_d;
  logic [WIDTH-1:0]   skid_q, skid_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               in_fire, out_fire;

  assign out_valid = (state_q != StEmpty);
  assign in_ready  = (state_q != StFull);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    // Flush drops the held entries but leaves the data registers untouched.
    if (flush) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = StOne;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = StFull;
          end else if (out_fire) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {STALL_W{1'b1}})) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits.
REQ-002 Parameter STALL_W, default 16: stall-counter width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; sampled on clk rising edge.
REQ-005 flush  input  1  synchronous kill of all held entries.
REQ-006 in_valid  input  1  upstream presents in_data.
REQ-007 in_ready  output  1  stage can accept in_data this cycle.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 out_valid  output  1  out_data holds a live entry.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 out_data  output  WIDTH  head-entry payload.
REQ-012 occupancy  output  2  live entries held: 0, 1 or 2.
REQ-013 stall_cnt  output  STALL_W  saturating count of back-pressured cycles.

Function
REQ-014 The stage SHALL hold up to two entries: main register (head) and skid register (second).
REQ-015 The stage SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-016 The stage SHALL implement states EMPTY (0 entries), ONE (main only) and FULL (main+skid).
REQ-017 The stage SHALL drive out_valid = (state != EMPTY), in_ready = (state != FULL), out_data = main register, and occupancy = 0/1/2 for EMPTY/ONE/FULL.
REQ-018 in_ready SHALL depend only on registered state, with no combinational path from out_ready.
REQ-019 EMPTY: on in_fire, main <= in_data and next state is ONE; otherwise it stays EMPTY.
REQ-020 ONE, in_fire & out_fire: main <= in_data and it stays ONE.
REQ-021 ONE, in_fire & !out_fire: skid <= in_data and next state is FULL; main is unchanged.
REQ-022 ONE, !in_fire & out_fire: next state is EMPTY.
REQ-023 ONE, neither fire: it stays ONE and holds all data.
REQ-024 FULL: on out_fire, main <= skid and next state is ONE; otherwise it stays FULL. in_fire is impossible because in_ready = 0.
REQ-025 Latency SHALL be 1 cycle: an entry accepted in cycle N in EMPTY appears with out_valid = 1 in cycle N+1.
REQ-026 Ordering SHALL be strict FIFO, with no drop and no duplication absent flush.
REQ-027 Flush priority:
- flush = 1 (and reset = 0): next state is EMPTY regardless of in_valid and out_ready.
- An in_fire in the same cycle is discarded.
- An out_fire in the same cycle counts as delivered.
REQ-028 Flush SHALL NOT modify the main or skid data registers; out_data keeps its last value while out_valid = 0.
REQ-029 stall_cnt SHALL increment by 1 in each cycle with out_valid & !out_ready.
REQ-030 stall_cnt SHALL saturate at 2^STALL_W-1 without wrap-around.
REQ-031 stall_cnt SHALL be unaffected by flush and SHALL be cleared only by reset.
REQ-032 Upstream holding in_valid while in_ready = 0 SHALL NOT alter state.
REQ-033 in_data SHALL be sampled only on in_fire.

Reset
REQ-034 On reset = 1 at a rising edge:
- state, main, skid and stall_cnt are all cleared to 0 (state = EMPTY).
- Outputs become out_valid = 0, in_ready = 1, occupancy = 0, out_data = 0 from the next cycle.
REQ-035 Reset SHALL take priority over flush and all handshakes, including mid-transfer.
REQ-036 Held entries SHALL be lost on reset, and the stage SHALL accept new input in the cycle after reset deasserts.

Verification
REQ-037 Pass-through: out_ready = 1, in_data = 0x11,0x22,0x33 on consecutive cycles -> out_data = 0x11,0x22,0x33 one cycle later each, occupancy = 1 throughout, stall_cnt = 0.
REQ-038 Skid fill: out_ready = 0, push 0xA then 0xB -> occupancy = 2 and in_ready = 0; with in_valid held, 0xC is not accepted; raise out_ready -> outputs 0xA then 0xB, then 0xC is accepted.
REQ-039 Flush: FULL with 0xA/0xB, assert flush with in_valid = 1 (0xC) -> next cycle occupancy = 0, out_valid = 0, and 0xC is never output.
REQ-040 Saturation: STALL_W = 4, out_valid = 1 and out_ready = 0 for 20 cycles -> stall_cnt = 15 and it holds 15.
REQ-041 Reset mid-operation: FULL with stall_cnt = 7, assert reset together with flush and out_ready -> next cycle state EMPTY, stall_cnt = 0, out_data = 0, in_ready = 1.
REQ-042 Random: random in_valid/out_ready over 10k cycles -> output sequence equals input sequence with no drop or duplication, occupancy never exceeds 2.
